// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// ALU operation classes, PC/writeback mux selects and the instruction class.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_NO_ALU         = 2'b00;
    localparam logic [1:0] ALU_BRANCH_COMPARE = 2'b01;
    localparam logic [1:0] ALU_ADD_OFFSET     = 2'b10;
    localparam logic [1:0] ALU_ARITHMETIC     = 2'b11;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef struct packed {
        logic rtype;
        logic ialu;
        logic load;
        logic store;
        logic branch;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic fence;
        logic system;
    } insn_class_t;

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// Combinational opcode/funct3 decode into a one-hot instruction class plus
// legal and system (halt) flags; zero latency, no handshake.
module multicycle_control_opcode_classifier
    import multicycle_control_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    output insn_class_t cls_o,
    output logic        legal_o,
    output logic        system_o
);

    logic bad_funct3;

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_RTYPE:  cls_o.rtype  = 1'b1;
            OP_IALU:   cls_o.ialu   = 1'b1;
            OP_LOAD:   cls_o.load   = 1'b1;
            OP_STORE:  cls_o.store  = 1'b1;
            OP_BRANCH: cls_o.branch = 1'b1;
            OP_LUI:    cls_o.lui    = 1'b1;
            OP_AUIPC:  cls_o.auipc  = 1'b1;
            OP_JAL:    cls_o.jal    = 1'b1;
            OP_JALR:   cls_o.jalr   = 1'b1;
            OP_FENCE:  cls_o.fence  = 1'b1;
            OP_SYSTEM: cls_o.system = 1'b1;
            default:   ;
        endcase
    end

    // Reserved width encodings: LD/LWU/unused loads, >32-bit stores, funct3 2/3 branches.
    always_comb begin
        bad_funct3 = (cls_o.load   && (funct3_i == 3'd3 || funct3_i >= 3'd6))
                  || (cls_o.store  && (funct3_i > 3'd2))
                  || (cls_o.branch && (funct3_i == 3'd2 || funct3_i == 3'd3));
    end

    assign legal_o  = (cls_o != '0) && !bad_funct3;
    assign system_o = cls_o.system;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; 3-5 cycles per insn plus memory waits,
// stalls on mem_ready in FETCH/MEM. MULTICYCLE_CTRL_PERF_EN adds cycle/instret counters.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_condition_match,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_operation,
    output logic        alu_src1,
    output logic        alu_src2,
    output logic        is_rtype,
    output logic        retire,
    output logic        halted,
    output logic        illegal_insn
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [63:0] cycle_count,
    output logic [63:0] instret_count
`endif
);

    localparam int HOLD = (RESET_PC_HOLD < 1) ? 1 : RESET_PC_HOLD;
    localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            halted_q, illegal_q, illegal_d;
    insn_class_t     cls;
    logic            legal, is_system;

    multicycle_control_opcode_classifier u_classifier (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .cls_o    (cls),
        .legal_o  (legal),
        .system_o (is_system)
    );

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        illegal_d  = illegal_q;
        unique case (state_q)
            ST_IDLE: begin
                if (idle_cnt_q == HOLD_LAST) state_d = ST_FETCH;
                else                         idle_cnt_d = idle_cnt_q + 1'b1;
            end
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!legal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (is_system) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.branch || cls.fence)    state_d = ST_FETCH;
                else if (cls.load || cls.store) state_d = ST_MEM;
                else                            state_d = ST_WB;
            end
            ST_MEM:  if (mem_ready) state_d = cls.load ? ST_WB : ST_FETCH;
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            halted_q   <= halted_q | (state_d == ST_HALT);
            illegal_q  <= illegal_d;
        end
    end

    // Gating on rst keeps every strobe low in the cycle reset is raised.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        alu_operation = ALU_NO_ALU;
        alu_src1      = 1'b0;
        alu_src2      = 1'b0;
        is_rtype      = 1'b0;
        retire        = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                ST_EXEC: begin
                    if (cls.branch) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        pc_src   = branch_condition_match ? PC_SRC_IMM : PC_SRC_PLUS4;
                    end else if (cls.fence) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = cls.store;
                    if (cls.store && mem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    pc_write  = 1'b1;
                    if (cls.load)                 wb_sel = WB_MEM;
                    else if (cls.lui)             wb_sel = WB_IMM;
                    else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
                    if (cls.jal)       pc_src = PC_SRC_IMM;
                    else if (cls.jalr) pc_src = PC_SRC_JALR;
                end
                default: ;
            endcase

            // ALU setup from EXEC is held through MEM and WB so the result stays valid.
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                if (cls.rtype) begin
                    alu_operation = ALU_ARITHMETIC;
                    is_rtype      = 1'b1;
                end else if (cls.ialu) begin
                    alu_operation = ALU_ARITHMETIC;
                    alu_src2      = 1'b1;
                end else if (cls.load || cls.store || cls.jalr) begin
                    alu_operation = ALU_ADD_OFFSET;
                    alu_src2      = 1'b1;
                end else if (cls.auipc) begin
                    alu_operation = ALU_ADD_OFFSET;
                    alu_src1      = 1'b1;
                    alu_src2      = 1'b1;
                end else if (cls.branch) begin
                    alu_operation = ALU_BRANCH_COMPARE;
                end
            end
        end
    end

    assign halted       = halted_q;
    assign illegal_insn = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [63:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (retire)             instret_cnt_q <= instret_cnt_q + 64'd1;
        end
    end

    assign cycle_count   = cycle_cnt_q;
    assign instret_count = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction reference model;
// a negedge monitor pops expected retire-time controls and latency.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       branch_condition_match = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
    logic [1:0] pc_src, wb_sel, alu_operation;
    logic       alu_src1, alu_src2, is_rtype, retire, halted, illegal_insn;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [63:0] cycle_count, instret_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.RESET_PC_HOLD(1)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .opcode                 (opcode),
        .funct3                 (funct3),
        .branch_condition_match (branch_condition_match),
        .mem_ready              (mem_ready),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_addr_sel           (mem_addr_sel),
        .ir_write               (ir_write),
        .pc_write               (pc_write),
        .pc_src                 (pc_src),
        .reg_write              (reg_write),
        .wb_sel                 (wb_sel),
        .alu_operation          (alu_operation),
        .alu_src1               (alu_src1),
        .alu_src2               (alu_src2),
        .is_rtype               (is_rtype),
        .retire                 (retire),
        .halted                 (halted),
        .illegal_insn           (illegal_insn)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_count            (cycle_count),
        .instret_count          (instret_count)
`endif
    );

    typedef struct {
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       src1;
        logic       src2;
        logic       rtype;
        logic       mem_we;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [16:0] outs();
        return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write,
                wb_sel, alu_operation, alu_src1, alu_src2, is_rtype, retire};
    endfunction

    // Reference: what the instruction must look like in its retire cycle, and how long it takes.
    function automatic exp_t model(input logic [6:0] op, input logic match, input int fw, input int mw);
        exp_t e;
        e.reg_write = 0; e.wb_sel = 0; e.pc_src = 0; e.alu_op = 0;
        e.src1 = 0; e.src2 = 0; e.rtype = 0; e.mem_we = 0;
        e.lat = fw + 3;
        case (op)
            7'b0110011: begin e.alu_op = 2'b11; e.rtype = 1; e.reg_write = 1; e.lat += 1; end
            7'b0010011: begin e.alu_op = 2'b11; e.src2 = 1; e.reg_write = 1; e.lat += 1; end
            7'b0000011: begin e.alu_op = 2'b10; e.src2 = 1; e.reg_write = 1; e.wb_sel = 1; e.lat += mw + 2; end
            7'b0100011: begin e.alu_op = 2'b10; e.src2 = 1; e.mem_we = 1; e.lat += mw + 1; end
            7'b1100011: begin e.alu_op = 2'b01; e.pc_src = match ? 2'd1 : 2'd0; end
            7'b0110111: begin e.reg_write = 1; e.wb_sel = 3; e.lat += 1; end
            7'b0010111: begin e.alu_op = 2'b10; e.src1 = 1; e.src2 = 1; e.reg_write = 1; e.lat += 1; end
            7'b1101111: begin e.reg_write = 1; e.wb_sel = 2; e.pc_src = 1; e.lat += 1; end
            7'b1100111: begin e.alu_op = 2'b10; e.src2 = 1; e.reg_write = 1; e.wb_sel = 2; e.pc_src = 2; e.lat += 1; end
            default: ;
        endcase
        return e;
    endfunction

    int  cyc = 0;
    int  start_cyc = 0;
    bit  in_insn = 0;
    int  retired = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            in_insn = 0;
            retired = 0;
        end else begin
            if (!in_insn && mem_req && !mem_addr_sel) begin
                in_insn   = 1;
                start_cyc = cyc;
            end
            if (pc_write || retire) check("pc_write_with_retire", {pc_write, retire}, 2'b11);
            if (reg_write) check("reg_write_only_at_retire", retire, 1'b1);
            if (retire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("retire_controls",
                          {reg_write, wb_sel, pc_src, alu_operation, alu_src1, alu_src2, is_rtype, mem_we},
                          {e.reg_write, e.wb_sel, e.pc_src, e.alu_op, e.src1, e.src2, e.rtype, e.mem_we});
                    check("latency", cyc - start_cyc + 1, e.lat);
                end
                in_insn = 0;
                retired++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic sel, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req === 1'b1 && mem_addr_sel === sel) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) check("mem_req_timeout", 1'b0, 1'b1);
    endtask

    task automatic handshake(input logic sel, input logic we, input int waits);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            #1;
            check("req_hold", {mem_req, mem_addr_sel, mem_we, pc_write, ir_write},
                  {1'b1, sel, we, 1'b0, 1'b0});
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic match,
                            input int fw, input int mw);
        bit ok;
        wait_req(1'b0, ok);
        if (!ok) return;
        opcode = op;
        funct3 = f3;
        branch_condition_match = match;
        exp_q.push_back(model(op, match, fw, mw));
        handshake(1'b0, 1'b0, fw);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            wait_req(1'b1, ok);
            if (!ok) return;
            handshake(1'b1, op == 7'b0100011, mw);
        end
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_outputs", {outs(), halted, illegal_insn}, '0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("reset_counters", {cycle_count, instret_count}, '0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_outputs", {outs(), halted, illegal_insn}, '0);
    endtask

    task automatic halt_case(input logic [6:0] op, input logic [2:0] f3, input logic illegal);
        bit ok;
        wait_req(1'b0, ok);
        if (!ok) return;
        opcode = op;
        funct3 = f3;
        handshake(1'b0, 1'b0, 0);
        check("decode_quiet", {outs(), halted}, '0);
        step();
        check("halt_flags", {halted, illegal_insn}, {1'b1, illegal});
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step();
            check("halt_absorbing", {outs(), halted, illegal_insn}, {17'h0, 1'b1, illegal});
        end
        do_reset();
        check("flags_cleared", {halted, illegal_insn}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops[10];
        logic [2:0] ld_f3[5];
        logic [2:0] br_f3[6];
        logic [6:0] op;
        logic [2:0] f3;
        bit ok;
        ops   = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        do_reset();

        run_insn(7'b0110011, 3'd0, 1'b0, 0, 0);
        run_insn(7'b0000011, 3'd2, 1'b0, 0, 3);
        run_insn(7'b1100011, 3'd0, 1'b1, 0, 0);
        run_insn(7'b1100011, 3'd0, 1'b0, 0, 0);
        run_insn(7'b1100111, 3'd0, 1'b0, 0, 0);
        run_insn(7'b0001111, 3'd0, 1'b0, 1, 0);

        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 9)];
            case (op)
                7'b0000011: f3 = ld_f3[$urandom_range(0, 4)];
                7'b0100011: f3 = 3'($urandom_range(0, 2));
                7'b1100011: f3 = br_f3[$urandom_range(0, 5)];
                default:    f3 = 3'($urandom_range(0, 7));
            endcase
            run_insn(op, f3, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        repeat (8) step();
        check("scoreboard_drained", exp_q.size(), 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("instret_count", instret_count, retired);
`endif

        // Store aborted by reset while waiting in MEM.
        wait_req(1'b0, ok);
        if (ok) begin
            opcode = 7'b0100011;
            funct3 = 3'd2;
            handshake(1'b0, 1'b0, 0);
            wait_req(1'b1, ok);
            if (ok) begin
                check("store_in_mem", {mem_req, mem_we, mem_addr_sel}, 3'b111);
                rst = 1'b1;
                #1;
                check("store_abort", {outs(), halted, illegal_insn}, '0);
                do_reset();
            end
        end

        halt_case(7'b1111111, 3'd0, 1'b1);
        halt_case(7'b1110011, 3'd0, 1'b0);
        halt_case(7'b0000011, 3'd3, 1'b1);
        halt_case(7'b0100011, 3'd3, 1'b1);
        halt_case(7'b1100011, 3'd2, 1'b1);

        run_insn(7'b0110011, 3'd0, 1'b0, 0, 0);
        repeat (6) step();
        check("post_halt_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
